ahb_arb_mux_master: RTL
=======================

AHB_ARB_MUX_MASTER -- requirements
Module: ahb_arb_mux_master

Interface
REQ-001 The block SHALL have parameter CHANNEL_NUM, default 3, meaning number of requesting channels (legal range 2..16).
REQ-002 The block SHALL have parameter PAYLOAD, default 34, meaning bit width of each channel payload.
REQ-003 The block SHALL have parameter ARB_MODE, default 1, meaning arbitration policy: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-004 The block SHALL have parameter TIMEOUT, default 16, meaning the number of consecutive hready-low cycles that aborts an ownership (legal range 2..255).
REQ-005 The block SHALL run on one clock with a synchronous, active-high reset.
REQ-006 Port hclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 Port hreset, input, 1 bit: synchronous, active-high reset.
REQ-008 Port req, input, CHANNEL_NUM bits: per-channel ownership request.
REQ-009 Port last, input, CHANNEL_NUM bits: per-channel final-beat marker for the current transfer or burst.
REQ-010 Port payload_in, input, CHANNEL_NUM x PAYLOAD bits: packed per-channel payload.
REQ-011 Port hready, input, 1 bit: downstream ready; a beat completes on a cycle with hready=1.
REQ-012 Port grant, output, CHANNEL_NUM bits: registered one-hot owner, or all zero.
REQ-013 Port payload_out, output, PAYLOAD bits: registered payload of the owner.
REQ-014 Port valid_out, output, 1 bit: payload_out holds a beat launched by the owner.
REQ-015 Port timeout_err, output, 1 bit: one-cycle pulse when an ownership is aborted by timeout.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and OWN.
REQ-017 In IDLE with req != 0, the arbiter SHALL select a winner; on the next cycle the FSM SHALL be in OWN, with grant one-hot on the winner.
REQ-018 In IDLE with req == 0, the block SHALL stay in IDLE with grant=0 and valid_out=0.
REQ-019 ARB_MODE=0: the lowest-index asserted req SHALL win.
REQ-020 ARB_MODE=1: the first asserted req at or above the rr pointer SHALL win, searching upward and wrapping from CHANNEL_NUM-1 to 0.
REQ-021 In ARB_MODE=1, the rr pointer SHALL update to (winner+1) mod CHANNEL_NUM when an ownership ends.
REQ-022 In OWN with hready=1, payload_out SHALL load payload_in[owner] and valid_out SHALL be 1 on the next cycle.
REQ-023 In OWN with hready=0, payload_out and valid_out SHALL hold their values.
REQ-024 Ownership SHALL end on a cycle in OWN with hready=1 and last[owner]=1; that beat SHALL still be loaded into payload_out.
REQ-025 At ownership end, the block SHALL re-arbitrate in the same cycle over the current req, with the rr pointer already advanced; it SHALL enter OWN with the new grant if any req is set, else IDLE with grant=0.
REQ-026 Back-to-back ownerships SHALL therefore have zero idle cycles.
REQ-027 req[owner] deasserting during OWN SHALL be ignored; ownership is held until REQ-024 or REQ-029.
REQ-028 A stall counter SHALL count consecutive OWN cycles with hready=0, and SHALL clear on any hready=1 cycle or on leaving OWN.
REQ-029 When the stall counter reaches TIMEOUT-1 with hready still 0, the block SHALL, on the next cycle, pulse timeout_err for 1 cycle, clear grant, clear valid_out, and go to IDLE; in round-robin mode the rr pointer SHALL advance past the aborted owner.
REQ-030 When a channel is not the owner, its last input and its payload_in SHALL have no effect.
REQ-031 grant SHALL never have more than one bit set.
REQ-032 No input path SHALL reach an output combinationally; all outputs SHALL be registered.

Reset
REQ-033 While hreset=1 at a clock edge, the block SHALL set state=IDLE, grant=0, payload_out=0, valid_out=0, timeout_err=0, rr pointer=0 and stall counter=0.
REQ-034 Reset asserted mid-ownership SHALL abort the ownership immediately, with no timeout_err pulse.
REQ-035 The first arbitration after reset SHALL occur on the first edge with hreset=0.

Verification
REQ-036 Round-robin, CHANNEL_NUM=3, req=3'b111, hready=1, last=3'b111 -> grant sequence 001, 010, 100, 001 on consecutive cycles, with no gap.
REQ-037 Fixed priority, ARB_MODE=0, req=3'b110 held -> grant stays 010 on every ownership; channel 2 is never granted.
REQ-038 Stall: owner ch0, hready=0 for 3 cycles, then hready=1 with payload_in[0]=34'h1234 -> payload_out and valid_out are held for 3 cycles, then payload_out=34'h1234 with valid_out=1.
REQ-039 Timeout: TIMEOUT=4, owner ch1, hready=0 held -> timeout_err is high for exactly 1 cycle after 4 stall cycles, grant=0 on the same cycle, and ch2 wins next if requesting.
REQ-040 Reset mid-burst: owner ch2, hreset=1 for 1 cycle -> all outputs are 0 on the next cycle, and arbitration restarts from pointer 0.
REQ-041 Release: owner drops req without last -> grant is held until hready=1 and last[owner]=1.

Source files
------------

// File: rtl/ahb_arb_mux_master.sv
// rtl/ahb_arb_mux_master.sv - multi-channel ownership arbiter with registered payload mux
// Two-state IDLE/OWN controller; re-arbitrates on the closing beat so ownerships run back to back.
module ahb_arb_mux_master #(
  parameter int CHANNEL_NUM = 3,
  parameter int PAYLOAD     = 34,
  parameter int ARB_MODE    = 1,
  parameter int TIMEOUT     = 16
) (
  input  logic                           hclk,
  input  logic                           hreset,
  input  logic [CHANNEL_NUM-1:0]         req,
  input  logic [CHANNEL_NUM-1:0]         last,
  input  logic [CHANNEL_NUM*PAYLOAD-1:0] payload_in,
  input  logic                           hready,
  output logic [CHANNEL_NUM-1:0]         grant,
  output logic [PAYLOAD-1:0]             payload_out,
  output logic                           valid_out,
  output logic                           timeout_err
);

  localparam int IW = $clog2(CHANNEL_NUM);
  localparam logic [IW:0]     NUM_W     = (IW+1)'(CHANNEL_NUM);
  localparam logic [IW-1:0]   LAST_IDX  = IW'(CHANNEL_NUM - 1);
  localparam logic [7:0]      STALL_MAX = 8'(TIMEOUT - 1);
  localparam logic [CHANNEL_NUM-1:0] ONE = {{(CHANNEL_NUM-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, OWN} state_t;

  state_t                 state_q;
  logic [CHANNEL_NUM-1:0] grant_q;
  logic [PAYLOAD-1:0]     payload_q;
  logic                   valid_q;
  logic                   terr_q;
  logic [IW-1:0]          owner_q;
  logic [IW-1:0]          rr_q;
  logic [7:0]             stall_q;

  logic [IW-1:0]          ptr_adv;
  logic [IW-1:0]          arb_base;
  logic                   win_found;
  logic [IW-1:0]          win_idx;
  logic [CHANNEL_NUM-1:0] win_onehot;
  logic [PAYLOAD-1:0]     owner_payload;
  logic                   stall_hit;

  assign ptr_adv       = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
  // While owning, the search already starts past the current owner so the closing beat can hand over.
  assign arb_base      = (ARB_MODE == 0) ? '0 : ((state_q == OWN) ? ptr_adv : rr_q);
  assign win_onehot    = ONE << win_idx;
  assign owner_payload = payload_in[owner_q*PAYLOAD +: PAYLOAD];
  assign stall_hit     = (stall_q == STALL_MAX);

  always_comb begin
    logic [IW:0] idx;
    idx       = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      idx = {1'b0, arb_base} + (IW+1)'(i);
      if (idx >= NUM_W) idx = idx - NUM_W;
      if (!win_found && req[idx[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx[IW-1:0];
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      payload_q <= '0;
      valid_q   <= 1'b0;
      terr_q    <= 1'b0;
      owner_q   <= '0;
      rr_q      <= '0;
      stall_q   <= '0;
    end else begin
      terr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          stall_q <= '0;
          valid_q <= 1'b0;
          if (win_found) begin
            state_q <= OWN;
            grant_q <= win_onehot;
            owner_q <= win_idx;
          end else begin
            grant_q <= '0;
          end
        end
        OWN: begin
          if (hready) begin
            stall_q   <= '0;
            payload_q <= owner_payload;
            valid_q   <= 1'b1;
            if (last[owner_q]) begin
              if (ARB_MODE != 0) rr_q <= ptr_adv;
              if (win_found) begin
                grant_q <= win_onehot;
                owner_q <= win_idx;
              end else begin
                state_q <= IDLE;
                grant_q <= '0;
              end
            end
          end else if (stall_hit) begin
            terr_q  <= 1'b1;
            grant_q <= '0;
            valid_q <= 1'b0;
            stall_q <= '0;
            state_q <= IDLE;
            if (ARB_MODE != 0) rr_q <= ptr_adv;
          end else begin
            stall_q <= stall_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign payload_out = payload_q;
  assign valid_out   = valid_q;
  assign timeout_err = terr_q;

endmodule
